mem_access_unit: RTL
====================

# mem_access_unit

Load/store initiator between the core's execute stage and the word-wide data RAM. It accepts one byte-addressed load or store request per transaction and drives the RAM's MemRead/MemWrite/address/write_data port. It performs RISC-V sub-word extraction with sign or zero extension, and read-modify-write for byte and halfword stores. It reports completion with a one-cycle pulse, and flags malformed requests.

## Interface
- DEPTH, 1024, RAM depth in 32-bit words; AW = $clog2(DEPTH)
- CLK  in  1  clock, all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- req  in  1  request strobe; sampled only in IDLE
- we  in  1  1 = store, 0 = load; sampled with req
- funct3  in  3  RISC-V size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- byte_addr  in  32  byte address; sampled with req
- wdata  in  32  store data, low-aligned; sampled with req
- rdata  out  32  extended load result; reset 0; holds until next successful load
- done  out  1  one-cycle completion pulse; reset 0
- err  out  1  valid with done; reset 0
- busy  out  1  high whenever state != IDLE; reset 0
- mem_read  out  1  RAM MemRead; reset 0
- mem_write  out  1  RAM MemWrite; reset 0
- mem_addr  out  AW  RAM word address = byte_addr[AW+1:2]; upper bits ignored; reset 0
- mem_wdata  out  32  RAM write_data; reset 0
- mem_rdata  in  32  RAM read_data, combinational from mem_addr while mem_read=1

## Operation
- States: IDLE, LOAD, STORE_RD, STORE_WR, DONE.
- IDLE, req=1: latch we, funct3, byte_addr, wdata. Next state:
  - illegal or misaligned request: DONE
  - load: LOAD
  - sw: STORE_WR
  - sb/sh: STORE_RD
- LOAD: mem_read=1. At the clock edge, register the extracted and extended lane into rdata. Next state DONE.
- STORE_RD: mem_read=1. Capture mem_rdata into an internal word. Next state STORE_WR.
- STORE_WR: mem_write=1. mem_wdata is the captured word with the target lane replaced (sb/sh) or wdata (sw). The RAM commits at the closing edge. Next state DONE.
- DONE: done=1, err as decided at acceptance. Next state IDLE. A req seen in DONE is ignored; the core re-issues it in IDLE.
- Lane selection is little-endian:
  - byte k = bits[8k+7:8k], with k = addr[1:0]
  - halfword = bits[16*addr[1]+15:16*addr[1]]
- Extension: b/h sign-extend, bu/hu zero-extend, w passes the word through.
- Illegal funct3 always gives err=1 with no memory access; rdata is unchanged. Illegal values:
  - loads: 011, 110, 111
  - stores: anything other than 000/001/010
- mem_read and mem_write are decoded from state only. They are never both high.
- mem_addr and mem_wdata are held stable for the whole access.

## Timing
- Request accepted at edge 0 (IDLE, req=1).
- lw/lb/lh/lbu/lhu: LOAD in cycle 1; done and valid rdata in cycle 2.
- sw: STORE_WR in cycle 1; RAM updated at edge 2; done in cycle 2.
- sb/sh: STORE_RD in cycle 1, STORE_WR in cycle 2, done in cycle 3.
- Error requests: done with err=1 in cycle 1; mem_read and mem_write stay 0.
- Earliest next acceptance is the cycle after done. Throughput is one load per 3 cycles.
- RST asserted in any state:
  - state goes to IDLE immediately
  - mem_read, mem_write, done, err, busy and rdata go to 0 without waiting for a clock
  - a STORE_WR interrupted before its edge commits nothing
- Back-to-back store then load to the same word: the load sees the new data, because the write commits before LOAD.

## Configuration
- MEM_ACCESS_MISALIGN_ERR_EN defined: misaligned accesses give err=1, no memory access, and rdata unchanged. Misaligned means:
  - h/hu/sh with addr[0]=1
  - w/sw with addr[1:0]!=0
- Undefined: alignment is not checked. Low address bits not used for lane selection are ignored:
  - halfword uses addr[1] only
  - word uses neither bit
- err is then raised only for illegal funct3.

## Test plan
- Word 5 = 0x8070_F1A2. lb at byte address 0x15 → done in cycle 2, rdata=0xFFFF_FFF1; lbu at 0x15 → rdata=0x0000_00F1.
- Word 5 = 0x8070_F1A2. lh at 0x16 → rdata=0xFFFF_8070; lw at 0x14 → rdata=0x8070_F1A2.
- Word 5 = 0x8070_F1A2. sb wdata=0x0000_0055 at 0x17 → mem_read in cycle 1, mem_write in cycle 2 with mem_wdata=0x5570_F1A2, done in cycle 3. A following lw at 0x14 returns 0x5570_F1A2.
- sw 0xDEAD_BEEF at 0x0 → single write cycle with mem_addr=0. An lh at 0x1:
  - with MEM_ACCESS_MISALIGN_ERR_EN: done with err=1 in cycle 1, no mem_read
  - without it: rdata=0xFFFF_BEEF, err=0
- Load with funct3=011 → err=1 in cycle 1, no memory access, rdata unchanged.
- RST asserted during STORE_WR of sw 0x1234_5678 to word 2, which holds 0 → mem_write drops immediately and busy=0. A later lw at 0x8 returns 0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Core-side request/response and data-RAM port of mem_access_unit.
// master = core + RAM side (bench), slave = the access unit.
interface mem_access_unit_if #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
);
  logic          req;
  logic          we;
  logic [2:0]    funct3;
  logic [31:0]   byte_addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          done;
  logic          err;
  logic          busy;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    output req, we, funct3, byte_addr, wdata, mem_rdata,
    input  rdata, done, err, busy, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, funct3, byte_addr, wdata, mem_rdata,
    output rdata, done, err, busy, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator to word RAM: loads 2 cycles, sw 2, sb/sh 3 (read-modify-write), errors 1; req only taken when idle.
// MEM_ACCESS_MISALIGN_ERR_EN: when defined, misaligned h/w accesses complete with err and no RAM access.
module mem_access_unit #(
  parameter int DEPTH = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_access_unit_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE_RD,
    S_STORE_WR,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_funct3;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_word;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_illegal;
  logic          w_misalign;
  logic          w_err;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_val;
  logic [31:0]   w_merged;
  logic          w_mem_read;
  logic          w_mem_write;
  logic          w_done;
  logic          w_busy;
  logic          w_unused;

  assign w_unused = &{1'b0, bus.byte_addr[31:AW+2]};

  always_comb begin
    w_illegal  = 1'b0;
    w_misalign = 1'b0;
    if (bus.we) begin
      w_illegal = !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_illegal = bus.funct3 inside {3'b011, 3'b110, 3'b111};
    end
`ifdef MEM_ACCESS_MISALIGN_ERR_EN
    w_misalign = ((bus.funct3[1:0] == 2'b01) && bus.byte_addr[0]) ||
                 ((bus.funct3[1:0] == 2'b10) && (bus.byte_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_err = w_illegal || w_misalign;
  end

  always_comb begin
    w_next      = r_state;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_done      = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.req) begin
          if (w_err) begin
            w_next = S_DONE;
          end else if (!bus.we) begin
            w_next = S_LOAD;
          end else if (bus.funct3[1:0] == 2'b10) begin
            w_next = S_STORE_WR;
          end else begin
            w_next = S_STORE_RD;
          end
        end
      end
      S_LOAD: begin
        w_mem_read = 1'b1;
        w_next     = S_DONE;
      end
      S_STORE_RD: begin
        w_mem_read = 1'b1;
        w_next     = S_STORE_WR;
      end
      S_STORE_WR: begin
        w_mem_write = 1'b1;
        w_next      = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Little-endian lane pick and RISC-V extension of the addressed load data.
  always_comb begin
    w_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = bus.mem_rdata[{r_addr[1], 4'b0000} +: 16];
    case (r_funct3)
      3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_val = {24'd0, w_byte};
      3'b101:  w_load_val = {16'd0, w_half};
      default: w_load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = r_word;
    case (r_funct3[1:0])
      2'b00:   w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_merged = r_wdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_word   <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && bus.req) begin
        r_funct3 <= bus.funct3;
        r_addr   <= bus.byte_addr[AW+1:0];
        r_wdata  <= bus.wdata;
        r_err    <= w_err;
      end
      if (r_state == S_LOAD) begin
        r_rdata <= w_load_val;
      end
      if (r_state == S_STORE_RD) begin
        r_word <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = r_addr[AW+1:2];
  assign bus.mem_wdata = w_merged;
  assign bus.done      = w_done;
  assign bus.err       = w_done && r_err;
  assign bus.busy      = w_busy;
  assign bus.rdata     = r_rdata;
endmodule
